// File: rtl/uart_receiver_if.sv
// Serial line, control and received-byte signals of the UART receiver.
interface uart_receiver_if;
  logic       RxD;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_PERROR;
  logic       Rx_FERROR;

  modport master (
    output RxD, baud_select, Rx_EN,
    input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );

  modport slave (
    input  RxD, baud_select, Rx_EN,
    output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, even parity, 1 stop; 16x oversampled.
// Define UART_RX_MAJORITY_VOTE_EN for a 2-of-3 vote over samples 7/8/9 of each bit.
module uart_receiver #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input logic            clk,
  input logic            reset,
  uart_receiver_if.slave rx
);

  function automatic int unsigned div_of(input int unsigned baud);
    int unsigned d;
    d = (CLK_HZ + 8 * baud) / (16 * baud);
    return (d == 0) ? 1 : d;
  endfunction

  localparam int unsigned DIV_TAB [8] = '{
    div_of(300),   div_of(1200),  div_of(4800),  div_of(9600),
    div_of(19200), div_of(38400), div_of(57600), div_of(115200)
  };
  localparam int unsigned DW = $clog2(DIV_TAB[0] + 1);

  typedef enum logic [2:0] {
    OFF, IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [2:0]    baud_q, baud_d;
  logic [DW-1:0] div_q, div_d, div_m1;
  logic [3:0]    tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          par_err_q, par_err_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          rxd_s, tick, decide, bit_val;

  assign rxd_s  = sync_q[1];
  assign div_m1 = DW'(DIV_TAB[baud_q] - 1);
  assign tick   = (div_q == div_m1);

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] vote_q, vote_d;
  // vote_q holds samples 7 and 8; the live line is sample 9
  assign decide  = tick && (tick_q == 4'd8);
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);
`else
  assign decide  = tick && (tick_q == 4'd7);
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    div_d     = div_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote_d    = vote_q;
    if (tick && (tick_q == 4'd6)) vote_d[0] = rxd_s;
    if (tick && (tick_q == 4'd7)) vote_d[1] = rxd_s;
`endif

    if (state_q inside {START, DATA, PARITY, STOP}) begin
      if (tick) begin
        div_d  = '0;
        tick_d = tick_q + 4'd1;
      end else begin
        div_d  = div_q + DW'(1);
      end
    end

    case (state_q)
      OFF: begin
        if (rx.Rx_EN) state_d = IDLE;
      end
      IDLE: begin
        if (!rxd_s) begin
          state_d = START;
          baud_d  = rx.baud_select;
          div_d   = '0;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (decide) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift_d = {bit_val, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (decide) begin
          par_err_d = bit_val ^ (^shift_q);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          data_d  = shift_q;
          perr_d  = par_err_q;
          ferr_d  = ~bit_val;
          valid_d = 1'b1;
          state_d = bit_val ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxd_s) state_d = IDLE;
      end
      default: state_d = OFF;
    endcase

    // Disable wins over a frame completing in the same cycle: nothing is published.
    if (!rx.Rx_EN) begin
      state_d = OFF;
      valid_d = 1'b0;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= OFF;
      sync_q    <= '1;
      baud_q    <= '0;
      div_q     <= '0;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q    <= '1;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], rx.RxD};
      baud_q    <= baud_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q    <= vote_d;
`endif
    end
  end

  assign rx.Rx_DATA   = data_q;
  assign rx.Rx_VALID  = valid_q;
  assign rx.Rx_PERROR = perr_q;
  assign rx.Rx_FERROR = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: one instance at 50 MHz, one at 4 MHz for slower rates and random frames.
module tb_uart_receiver;
  localparam int unsigned CLK_A = 50000000;
  localparam int unsigned CLK_B = 4000000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_receiver_if ifa ();
  uart_receiver_if ifb ();

  uart_receiver #(.CLK_HZ(CLK_A)) dut_a (.clk(clk), .reset(reset), .rx(ifa.slave));
  uart_receiver #(.CLK_HZ(CLK_B)) dut_b (.clk(clk), .reset(reset), .rx(ifb.slave));

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  typedef struct {
    logic [7:0]  data;
    logic        flip;
    logic        stop;
    int unsigned low_bits;
    int unsigned idle_bits;
    logic [7:0]  exp_data;
    logic        exp_pe;
    logic        exp_fe;
  } vec_t;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned va_cnt = 0;
  rec_t        qb [$];
  rec_t        eq [$];

  always @(negedge clk) begin
    if (ifa.Rx_VALID === 1'b1) va_cnt++;
    if (ifb.Rx_VALID === 1'b1) qb.push_back(rec_t'({ifb.Rx_DATA, ifb.Rx_PERROR, ifb.Rx_FERROR}));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int unsigned bit_clks(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned rates [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
    int unsigned b;
    b = rates[sel];
    return 16 * ((clk_hz + 8 * b) / (16 * b));
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] d, input logic flip, input logic stop);
    return {stop, (^d) ^ flip, d, 1'b0};
  endfunction

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rxd(input bit b_sel, input logic v);
    if (b_sel) ifb.RxD = v;
    else       ifa.RxD = v;
  endtask

  task automatic send_bits(input bit b_sel, input logic [10:0] f, input int unsigned nbits,
                           input int unsigned per);
    for (int unsigned i = 0; i < nbits; i++) begin
      set_rxd(b_sel, f[i]);
      wait_clks(per);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: run still active at time %0t, required finish before it", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tab [5];
    int unsigned per_a, per_b, base;
    logic [10:0] f;
    logic [2:0]  sel;
    logic [7:0]  d;
    logic        flip, stop;

    tab[0] = '{8'hA5, 1'b0, 1'b1, 0, 1,  8'hA5, 1'b0, 1'b0};
    tab[1] = '{8'h01, 1'b1, 1'b1, 0, 1,  8'h01, 1'b1, 1'b0};
    tab[2] = '{8'h3C, 1'b0, 1'b0, 2, 12, 8'h3C, 1'b0, 1'b1};
    tab[3] = '{8'hFF, 1'b1, 1'b1, 0, 1,  8'hFF, 1'b1, 1'b0};
    tab[4] = '{8'h80, 1'b0, 1'b0, 0, 1,  8'h80, 1'b0, 1'b1};

    per_a = bit_clks(CLK_A, 3'b111);
    per_b = bit_clks(CLK_B, 3'b011);

    ifa.RxD = 1'b1; ifa.Rx_EN = 1'b0; ifa.baud_select = 3'b111;
    ifb.RxD = 1'b1; ifb.Rx_EN = 1'b0; ifb.baud_select = 3'b011;
    reset = 1'b1;
    wait_clks(5);
    check("rst_data_a",  32'(ifa.Rx_DATA),   32'h00);
    check("rst_valid_a", 32'(ifa.Rx_VALID),  32'h0);
    check("rst_perr_a",  32'(ifa.Rx_PERROR), 32'h0);
    check("rst_ferr_a",  32'(ifa.Rx_FERROR), 32'h0);
    check("rst_data_b",  32'(ifb.Rx_DATA),   32'h00);
    check("rst_valid_b", 32'(ifb.Rx_VALID),  32'h0);
    reset = 1'b0;
    wait_clks(3);
    ifa.Rx_EN = 1'b1;
    ifb.Rx_EN = 1'b1;
    wait_clks(5);

    for (int unsigned i = 0; i < 5; i++) begin
      base = va_cnt;
      send_bits(1'b0, frame(tab[i].data, tab[i].flip, tab[i].stop), 11, per_a);
      wait_clks(tab[i].low_bits * per_a);
      ifa.RxD = 1'b1;
      wait_clks(tab[i].idle_bits * per_a);
      check($sformatf("vec%0d_valid_cnt", i), 32'(va_cnt - base), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(ifa.Rx_DATA),   32'(tab[i].exp_data));
      check($sformatf("vec%0d_perr", i), 32'(ifa.Rx_PERROR), 32'(tab[i].exp_pe));
      check($sformatf("vec%0d_ferr", i), 32'(ifa.Rx_FERROR), 32'(tab[i].exp_fe));
    end

    // four-tick low glitch while idle
    base = va_cnt;
    ifa.RxD = 1'b0;
    wait_clks(4 * (per_a / 16));
    ifa.RxD = 1'b1;
    wait_clks(2 * per_a);
    check("glitch_valid_cnt", 32'(va_cnt - base),   32'd0);
    check("glitch_data",      32'(ifa.Rx_DATA),     32'h80);
    check("glitch_ferr",      32'(ifa.Rx_FERROR),   32'h1);
    send_bits(1'b0, frame(8'h5A, 1'b0, 1'b1), 11, per_a);
    wait_clks(per_a);
    check("post_glitch_valid_cnt", 32'(va_cnt - base), 32'd1);
    check("post_glitch_data",      32'(ifa.Rx_DATA),   32'h5A);
    check("post_glitch_ferr",      32'(ifa.Rx_FERROR), 32'h0);

    // back-to-back frames at 9600 on the slow instance
    qb.delete();
    send_bits(1'b1, frame(8'h55, 1'b0, 1'b1), 11, per_b);
    send_bits(1'b1, frame(8'hAA, 1'b0, 1'b1), 11, per_b);
    wait_clks(per_b);
    check("b2b_count", 32'(qb.size()), 32'd2);
    if (qb.size() == 2) begin
      check("b2b_first",  32'(qb[0]), 32'(rec_t'({8'h55, 1'b0, 1'b0})));
      check("b2b_second", 32'(qb[1]), 32'(rec_t'({8'hAA, 1'b0, 1'b0})));
    end

    // random frames, rate changes and mid-frame baud_select noise
    qb.delete();
    eq.delete();
    for (int unsigned k = 0; k < 8; k++) begin
      sel  = 3'(4 + $urandom_range(0, 3));
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      ifb.baud_select = sel;
      eq.push_back(rec_t'({d, flip, ~stop}));
      f = frame(d, flip, stop);
      send_bits(1'b1, f, 6, bit_clks(CLK_B, sel));
      ifb.baud_select = 3'($urandom);
      send_bits(1'b1, f >> 6, 5, bit_clks(CLK_B, sel));
      ifb.RxD = 1'b1;
      if (!stop || ($urandom_range(0, 1) == 1)) wait_clks(bit_clks(CLK_B, sel));
    end
    wait_clks(bit_clks(CLK_B, 3'b100));
    check("rand_count", 32'(qb.size()), 32'(eq.size()));
    for (int unsigned k = 0; k < eq.size(); k++) begin
      if (k < qb.size()) check($sformatf("rand_rec%0d", k), 32'(qb[k]), 32'(eq[k]));
    end

    // Rx_EN dropped during D3
    base = va_cnt;
    f = frame(8'hC3, 1'b0, 1'b1);
    send_bits(1'b0, f, 4, per_a);
    ifa.RxD = f[4];
    wait_clks(per_a / 2);
    ifa.Rx_EN = 1'b0;
    wait_clks(per_a / 2);
    ifa.RxD = 1'b1;
    wait_clks(2 * per_a);
    check("en_drop_valid_cnt", 32'(va_cnt - base), 32'd0);
    check("en_drop_data_held", 32'(ifa.Rx_DATA),   32'h5A);
    ifa.Rx_EN = 1'b1;
    wait_clks(per_a);
    send_bits(1'b0, frame(8'h7E, 1'b0, 1'b1), 11, per_a);
    wait_clks(per_a);
    check("en_7e_valid_cnt", 32'(va_cnt - base),   32'd1);
    check("en_7e_data",      32'(ifa.Rx_DATA),     32'h7E);
    check("en_7e_perr",      32'(ifa.Rx_PERROR),   32'h0);

    // reset asserted during D3
    base = va_cnt;
    ifa.baud_select = 3'b000;
    send_bits(1'b0, f, 4, 432);
    ifa.RxD = f[4];
    wait_clks(per_a / 2);
    reset = 1'b1;
    #1;
    check("rst_async_data", 32'(ifa.Rx_DATA), 32'h00);
    wait_clks(per_a / 2);
    ifa.RxD = 1'b1;
    wait_clks(4);
    reset = 1'b0;
    ifa.baud_select = 3'b111;
    wait_clks(per_a);
    check("rst_mid_valid_cnt", 32'(va_cnt - base),   32'd0);
    check("rst_mid_data",      32'(ifa.Rx_DATA),     32'h00);
    check("rst_mid_perr",      32'(ifa.Rx_PERROR),   32'h0);
    check("rst_mid_ferr",      32'(ifa.Rx_FERROR),   32'h0);
    send_bits(1'b0, frame(8'h7E, 1'b0, 1'b1), 11, per_a);
    wait_clks(per_a);
    check("rst_7e_valid_cnt", 32'(va_cnt - base), 32'd1);
    check("rst_7e_data",      32'(ifa.Rx_DATA),   32'h7E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
